matvec_stream_frontend: RTL and testbench
=========================================

# matvec_stream_frontend

Stream-side front end for the sequential 4x4 single-precision matrix-vector product core. Accepts a framed stream of 32-bit IEEE-754 words (16 matrix elements row-major, then 4 vector elements), assembles them into the core's parallel operand bus, and drives the core's input handshake. It then collects the 4-element product and re-serialises it onto an output stream. It sits between the host/UART word interface and the product core, acting as the core's initiator and result consumer.

## Interface

- WIDTH, 32, element width in bits (IEEE-754 single)
- N, 4, matrix dimension; frame length N*N+N = 20 words

- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- s_data  in  WIDTH  input word
- s_valid  in  1  input word valid
- s_last  in  1  marks final word of frame
- s_ready  out  1  front end accepts input word
- mat  out  N*N*WIDTH  matrix bus; element (r,c) at [(r*N+c)*WIDTH +: WIDTH]
- vec  out  N*WIDTH  vector bus; element i at [i*WIDTH +: WIDTH]
- core_i_valid  out  1  operands valid to core
- core_i_ready  in  1  core accepts operands
- prod  in  N*WIDTH  core product; element i at [i*WIDTH +: WIDTH]
- core_o_valid  in  1  core product valid
- core_o_ready  out  1  front end accepts product
- m_data  out  WIDTH  output word
- m_valid  out  1  output word valid
- m_last  out  1  marks product element N-1
- m_ready  in  1  downstream accepts output word
- frame_err  out  1  one-cycle pulse on framing error

## Operation

- States: LOAD, ISSUE, WAIT, SEND, DRAIN.
- LOAD: s_ready=1. On s_valid&&s_ready, word stored at index cnt (0..15 into mat, 16..19 into vec) and cnt increments.
  - s_last on cnt<19: frame dropped, cnt->0, frame_err pulses, stay in LOAD.
  - cnt==19 with s_last: cnt->0, ->ISSUE.
  - cnt==19 without s_last: frame dropped, cnt->0, frame_err pulses, ->DRAIN.
- DRAIN: s_ready=1, accepted words discarded. The first accepted word with s_last returns to LOAD. No further frame_err.
- ISSUE: core_i_valid=1 and held until core_i_valid&&core_i_ready, then ->WAIT.
- WAIT: core_o_ready=1. On core_o_valid&&core_o_ready, prod is captured into an internal result register, ->SEND.
- SEND: m_valid=1, m_data=result[oidx], m_last=(oidx==N-1). Each m_valid&&m_ready increments oidx. Acceptance with oidx==N-1 sets oidx->0, ->LOAD.
- mat/vec are written only in LOAD and are stable from ISSUE through SEND. A dropped frame may leave partially overwritten mat/vec, which is harmless because they are not issued.
- Data is passed bit-exact; no arithmetic in this block.
- The block processes one frame at a time. Input is not accepted in ISSUE, WAIT or SEND.
- s_ready, core_i_valid, core_o_ready, m_valid and m_last decode from the registered state and counters. m_data is muxed from registered result.

## Timing

- Reset (rst=0 at clk edge): state LOAD, cnt=0, oidx=0, mat=0, vec=0, result=0.
  - Outputs during and after reset: s_ready=1 (after first reset edge), core_i_valid=0, core_o_ready=0, m_valid=0, m_last=0, m_data=0, frame_err=0.
- Reset mid-operation abandons the frame and all state returns to the reset values. The core shares rst, so no stale product is presented.
- Accepting word 19 at edge k gives core_i_valid=1 in cycle k+1.
- Core handshake at edge j gives core_o_ready=1 in cycle j+1.
- Product capture at edge p gives m_valid=1 with element 0 in cycle p+1. Minimum of 4 further cycles to drain with m_ready=1.
- Last output accepted at edge q gives s_ready=1 in cycle q+1.
- Stalls (s_valid=0, core_i_ready=0, core_o_valid=0, m_ready=0) hold all state and outputs; there is no timeout.
- frame_err is high for exactly the cycle after the offending acceptance edge.

## Test plan

- Identity matrix (0x3F800000 diagonal, 0 elsewhere), vec [1,2,3,4] -> m_data 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on 4 accepted beats, m_last only on the 4th, s_ready back 1 cycle later.
- Same frame with s_valid toggling every other cycle, core_i_ready low 5 cycles, m_ready low 3 cycles mid-SEND -> identical output words, core_i_valid held high throughout the stall, no word lost or duplicated.
- s_last on word 7 -> frame_err pulse, no core_i_valid. Next good 20-word frame produces a correct result.
- 20 words with no s_last, then 3 words ending with s_last -> one frame_err pulse, those 23 words ignored. Next good frame processed correctly.
- rst=0 for 1 cycle during SEND after element 1 -> m_valid=0, s_ready=1 after reset. A new frame yields only its own 4 results.
- Two back-to-back frames with different vectors -> two correct 4-word results in order, mat/vec stable while core_i_valid=1.

Source files
------------

// File: rtl/matvec_stream_frontend.sv
// Stream front end for the 4x4 matrix-vector product core: assembles a 20-word
// operand frame, hands it to the core, then serialises the 4-word product.
module matvec_stream_frontend #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [N*N*WIDTH-1:0]   mat,
    output logic [N*WIDTH-1:0]     vec,
    output logic                   core_i_valid,
    input  logic                   core_i_ready,
    input  logic [N*WIDTH-1:0]     prod,
    input  logic                   core_o_valid,
    output logic                   core_o_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   frame_err
);

    // state | meaning
    // LOAD  | accepting frame words into mat/vec
    // ISSUE | presenting operands to the core
    // WAIT  | waiting for the core product
    // SEND  | serialising the product onto the output stream
    // DRAIN | discarding words of an over-long frame up to its s_last
    typedef enum logic [2:0] {LOAD, ISSUE, WAIT, SEND, DRAIN} state_t;

    localparam int FRAME = N * N + N;
    localparam int CW    = $clog2(FRAME);
    localparam int OW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);
    localparam logic [CW-1:0] MAT_END  = CW'(N * N);
    localparam logic [OW-1:0] OIDX_END = OW'(N - 1);

    state_t              state, state_nx;
    logic [CW-1:0]       cnt;
    logic [OW-1:0]       oidx;
    logic [N*WIDTH-1:0]  result;
    logic                s_acc;
    logic                m_acc;

    assign s_acc  = s_valid && s_ready;
    assign m_acc  = m_valid && m_ready;
    assign m_data = result[int'(oidx) * WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD: begin
                if (s_acc && cnt == LAST_IDX) begin
                    state_nx = s_last ? ISSUE : DRAIN;
                end
            end
            DRAIN: begin
                if (s_acc && s_last) begin
                    state_nx = LOAD;
                end
            end
            ISSUE: begin
                if (core_i_ready) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (core_o_valid) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (m_acc && oidx == OIDX_END) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        s_ready      = 1'b0;
        core_i_valid = 1'b0;
        core_o_ready = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        case (state)
            LOAD:    s_ready      = 1'b1;
            DRAIN:   s_ready      = 1'b1;
            ISSUE:   core_i_valid = 1'b1;
            WAIT:    core_o_ready = 1'b1;
            SEND: begin
                m_valid = 1'b1;
                m_last  = (oidx == OIDX_END);
            end
            default: s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            oidx      <= '0;
            mat       <= '0;
            vec       <= '0;
            result    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state == LOAD && s_acc) begin
                if (cnt < MAT_END) begin
                    mat[int'(cnt) * WIDTH +: WIDTH] <= s_data;
                end else begin
                    vec[(int'(cnt) - N * N) * WIDTH +: WIDTH] <= s_data;
                end
                // A frame ends either at word 19 or at an early s_last; only
                // the exact match is a good frame.
                if (cnt == LAST_IDX || s_last) begin
                    cnt       <= '0;
                    frame_err <= !(cnt == LAST_IDX && s_last);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (state == WAIT && core_o_valid) begin
                result <= prod;
            end
            if (state == SEND && m_acc) begin
                oidx <= (oidx == OIDX_END) ? '0 : oidx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matvec_stream_frontend.sv
// Directed bench for matvec_stream_frontend; the bench plays host, product core
// and downstream sink with hand-computed operand and product words.
module tb_matvec_stream_frontend;

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F5  = 32'h40A00000;
    localparam logic [31:0] F6  = 32'h40C00000;
    localparam logic [31:0] F7  = 32'h40E00000;
    localparam logic [31:0] F8  = 32'h41000000;
    localparam logic [31:0] F9  = 32'h41100000;
    localparam logic [31:0] F10 = 32'h41200000;
    localparam logic [31:0] F11 = 32'h41300000;
    localparam logic [31:0] F12 = 32'h41400000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [511:0]  mat;
    logic [127:0]  vec;
    logic          core_i_valid;
    logic          core_i_ready = 1'b0;
    logic [127:0]  prod = '0;
    logic          core_o_valid = 1'b0;
    logic          core_o_ready;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          frame_err;

    int            checks = 0;
    int            errors = 0;
    int            ferr_cnt = 0;
    int            ferr_base;
    logic          ferr_last;
    logic [31:0]   fm [20];

    matvec_stream_frontend #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .mat(mat), .vec(vec),
        .core_i_valid(core_i_valid), .core_i_ready(core_i_ready),
        .prod(prod), .core_o_valid(core_o_valid), .core_o_ready(core_o_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [31:0] diag, input logic [31:0] v0, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [31:0] v3);
        for (int k = 0; k < 16; k++) fm[k] = (k % 5 == 0) ? diag : 32'h0;
        fm[16] = v0; fm[17] = v1; fm[18] = v2; fm[19] = v3;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        s_data = d; s_last = l; s_valid = 1'b1;
        for (int t = 0; t < 50 && !s_ready; t++) step();
        chk("s_ready_wait", s_ready, 1'b1);
        step();
        ferr_last = frame_err;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int k = 0; k < 20; k++) begin
            send_word(fm[k], k == 19);
            if (gaps && k != 19) step();
        end
    endtask

    task automatic chk_operands(input string tag);
        for (int k = 0; k < 16; k++) chk({tag, "_mat"}, mat[k*32 +: 32], fm[k]);
        for (int i = 0; i < 4; i++) chk({tag, "_vec"}, vec[i*32 +: 32], fm[16 + i]);
    endtask

    // Core side: immediately after word 19 is accepted, operands must be offered.
    task automatic core_exchange(input logic [127:0] p, input int istall);
        chk("civ_latency", core_i_valid, 1'b1);
        chk_operands("issue");
        for (int s = 0; s < istall; s++) begin
            step();
            chk("civ_hold", core_i_valid, 1'b1);
            chk("mat_stable", mat[15*32 +: 32], fm[15]);
            chk("vec_stable", vec[3*32 +: 32], fm[19]);
        end
        core_i_ready = 1'b1;
        step();
        core_i_ready = 1'b0;
        chk("civ_drop", core_i_valid, 1'b0);
        chk("cor_latency", core_o_ready, 1'b1);
        prod = p; core_o_valid = 1'b1;
        step();
        core_o_valid = 1'b0;
        prod = '0;
        chk("mv_latency", m_valid, 1'b1);
    endtask

    task automatic recv(input logic [127:0] p, input int nbeats, input int stall_at, input int stall_len);
        for (int i = 0; i < nbeats; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk("mv_stall", m_valid, 1'b1);
                    chk("md_stall", m_data, p[i*32 +: 32]);
                end
            end
            chk("m_valid", m_valid, 1'b1);
            chk("m_data", m_data, p[i*32 +: 32]);
            chk("m_last", m_last, i == 3);
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
        end
        if (nbeats == 4) begin
            chk("s_ready_after", s_ready, 1'b1);
            chk("m_valid_after", m_valid, 1'b0);
        end
    endtask

    initial begin
        logic [127:0] pa, pb, pc;
        pa = {F4, F3, F2, F1};
        pb = {F8, F7, F6, F5};
        pc = {F12, F11, F10, F9};

        // Reset state
        step(); step();
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_civ", core_i_valid, 1'b0);
        chk("rst_cor", core_o_ready, 1'b0);
        chk("rst_mv", m_valid, 1'b0);
        chk("rst_ml", m_last, 1'b0);
        chk("rst_md", m_data, 32'h0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_mat", mat[31:0], 32'h0);
        rst = 1'b1;
        step();

        // Identity frame, no stalls
        set_frame(F1, F1, F2, F3, F4);
        send_frame(1'b0);
        core_exchange(pa, 0);
        recv(pa, 4, -1, 0);

        // Same frame with gaps and stalls on every side
        send_frame(1'b1);
        core_exchange(pa, 5);
        recv(pa, 4, 2, 3);

        // Early s_last on word 7
        ferr_base = ferr_cnt;
        set_frame(F2, F9, F9, F9, F9);
        for (int k = 0; k < 8; k++) send_word(fm[k], k == 7);
        chk("early_ferr", ferr_last, 1'b1);
        step();
        chk("early_ferr_pulse", frame_err, 1'b0);
        chk("early_civ", core_i_valid, 1'b0);
        chk("early_s_ready", s_ready, 1'b1);
        chk("early_ferr_cnt", ferr_cnt - ferr_base, 1);
        set_frame(F1, F1, F2, F3, F4);
        send_frame(1'b0);
        core_exchange(pa, 0);
        recv(pa, 4, -1, 0);

        // Over-long frame: 20 words without s_last, 3 more ending in s_last
        ferr_base = ferr_cnt;
        for (int k = 0; k < 20; k++) fm[k] = 32'h10000000 + k;
        for (int k = 0; k < 20; k++) send_word(fm[k], 1'b0);
        chk("long_ferr", ferr_last, 1'b1);
        for (int k = 0; k < 3; k++) send_word(32'hDEAD0000 + k, k == 2);
        chk("long_civ", core_i_valid, 1'b0);
        chk("long_s_ready", s_ready, 1'b1);
        chk("long_ferr_cnt", ferr_cnt - ferr_base, 1);
        chk("drain_no_write", vec[31:0], 32'h10000010);
        set_frame(F1, F5, F6, F7, F8);
        send_frame(1'b0);
        core_exchange(pb, 0);
        recv(pb, 4, -1, 0);

        // Reset during SEND after element 1
        set_frame(F1, F1, F2, F3, F4);
        send_frame(1'b0);
        core_exchange(pa, 0);
        recv(pa, 2, -1, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mid_rst_mv", m_valid, 1'b0);
        chk("mid_rst_s_ready", s_ready, 1'b1);
        chk("mid_rst_md", m_data, 32'h0);
        chk("mid_rst_civ", core_i_valid, 1'b0);
        set_frame(F1, F5, F6, F7, F8);
        send_frame(1'b0);
        core_exchange(pb, 0);
        recv(pb, 4, -1, 0);

        // Back-to-back frames with different vectors
        set_frame(F1, F1, F2, F3, F4);
        send_frame(1'b0);
        core_exchange(pa, 2);
        recv(pa, 4, -1, 0);
        set_frame(F1, F9, F10, F11, F12);
        send_frame(1'b0);
        core_exchange(pc, 2);
        recv(pc, 4, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
